// File: rtl/cl_key_sequencer.sv
// Key-supply sequencer for Cute-Lock time-windowed FSMs: stores NUM_KEYS key words and
// replays them one window at a time, holding the locked block in reset until aligned.
module cl_key_sequencer #(
    parameter  int KEY_W    = 18,
    parameter  int NUM_KEYS = 6,
    parameter  int WIN_LEN  = 5,
    localparam int IDX_W    = $clog2(NUM_KEYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_valid,
    input  logic [IDX_W-1:0] ld_idx,
    input  logic [KEY_W-1:0] ld_data,
    output logic             ld_ready,
    input  logic             start,
    input  logic             clear,
    output logic [KEY_W-1:0] key_out,
    output logic             lock_rst,
    output logic             running,
    output logic [IDX_W-1:0] win_idx,
    output logic             ld_err
);

    localparam int PERIOD = NUM_KEYS * WIN_LEN;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t             state, state_nxt;
    logic [KEY_W-1:0]   slots [NUM_KEYS];
    logic [NUM_KEYS-1:0] mask;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [IDX_W-1:0]   win_q, win_nxt;
    logic [KEY_W-1:0]   key_q, slot0_nxt;
    logic               err_q;
    logic               idle, idx_ok, wr_en, idx_bad, start_ok, start_bad;

    // clear outranks start and writes, so every IDLE action is gated by !clear
    always_comb begin
        idle      = (state == IDLE) && !clear;
        idx_ok    = (ld_idx <= LAST_IDX);
        wr_en     = idle && ld_valid && idx_ok;
        idx_bad   = idle && ld_valid && !idx_ok;
        start_ok  = idle && start && (&mask);
        start_bad = idle && start && !(&mask);
        cnt_nxt   = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        win_nxt   = IDX_W'(int'(cnt_nxt) / WIN_LEN);
        slot0_nxt = (wr_en && (ld_idx == '0)) ? ld_data : slots[0];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = SYNC;
            SYNC:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
        if (clear) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int i = 0; i < NUM_KEYS; i++) slots[i] <= '0;
            mask  <= '0;
            cnt   <= '0;
            win_q <= '0;
            key_q <= '0;
            if (rst) err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (wr_en && (ld_idx == IDX_W'(i))) begin
                    slots[i] <= ld_data;
                    mask[i]  <= 1'b1;
                end
            end
            if (idx_bad || start_bad) err_q <= 1'b1;
            // key_q is loaded one edge ahead so it switches together with cnt
            case (state)
                IDLE: if (start_ok) key_q <= slot0_nxt;
                SYNC: begin
                    cnt   <= '0;
                    win_q <= '0;
                    key_q <= slots[0];
                end
                RUN: begin
                    cnt   <= cnt_nxt;
                    win_q <= win_nxt;
                    key_q <= slots[win_nxt];
                end
                default: ;
            endcase
        end
    end

    assign ld_ready = (state == IDLE);
    assign lock_rst = (state != RUN);
    assign running  = (state == RUN);
    assign key_out  = key_q;
    assign win_idx  = win_q;
    assign ld_err   = err_q;

endmodule

// File: tb/tb_cl_key_sequencer.sv
// Directed bench for cl_key_sequencer: loading, sequencing, error flag, clear and reset.
module tb_cl_key_sequencer;

    logic        clk = 1'b0;
    logic        rst, ld_valid, start, clear;
    logic [2:0]  ld_idx;
    logic [17:0] ld_data;
    logic        ld_ready, lock_rst, running, ld_err;
    logic [17:0] key_out;
    logic [2:0]  win_idx;

    int compared = 0;
    int mismatched = 0;

    logic [17:0] keys [6] = '{18'h2E9C1, 18'h1B1D8, 18'h3C2CB, 18'h209EC, 18'h0AC2D, 18'h017FD};

    cl_key_sequencer #(.KEY_W(18), .NUM_KEYS(6), .WIN_LEN(5)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_idx(ld_idx), .ld_data(ld_data),
        .ld_ready(ld_ready), .start(start), .clear(clear), .key_out(key_out),
        .lock_rst(lock_rst), .running(running), .win_idx(win_idx), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load(input int idx, input logic [17:0] data);
        ld_valid = 1'b1;
        ld_idx   = 3'(idx);
        ld_data  = data;
        tick();
        ld_valid = 1'b0;
    endtask

    task automatic load_all();
        for (int i = 0; i < 6; i++) load(i, keys[i]);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic err);
        chk({tag, "_key"}, 32'(key_out), 0);
        chk({tag, "_lock_rst"}, 32'(lock_rst), 1);
        chk({tag, "_running"}, 32'(running), 0);
        chk({tag, "_ready"}, 32'(ld_ready), 1);
        chk({tag, "_win"}, 32'(win_idx), 0);
        chk({tag, "_err"}, 32'(err), 32'(ld_err));
    endtask

    initial begin
        rst = 1'b1; ld_valid = 1'b0; ld_idx = '0; ld_data = '0; start = 1'b0; clear = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle("reset", 1'b0);
        chk("reset_err", 32'(ld_err), 0);

        // Full load, start, one SYNC cycle, then a full period plus the wrap
        load_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sync_lock_rst", 32'(lock_rst), 1);
        chk("sync_key", 32'(key_out), 32'(keys[0]));
        chk("sync_running", 32'(running), 0);
        chk("sync_ready", 32'(ld_ready), 0);
        chk("sync_win", 32'(win_idx), 0);
        for (int c = 0; c <= 30; c++) begin
            tick();
            chk($sformatf("run_key_c%0d", c), 32'(key_out), 32'(keys[(c % 30) / 5]));
            chk($sformatf("run_win_c%0d", c), 32'(win_idx), 32'((c % 30) / 5));
            chk($sformatf("run_lock_rst_c%0d", c), 32'(lock_rst), 0);
            chk($sformatf("run_running_c%0d", c), 32'(running), 1);
        end
        // Writes and start in RUN are ignored and raise no error (cnt 0 -> 1)
        ld_valid = 1'b1; ld_idx = 3'd7; ld_data = 18'h3FFFF; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        chk("run_ignore_err", 32'(ld_err), 0);
        chk("run_ignore_running", 32'(running), 1);
        chk("run_ignore_key", 32'(key_out), 32'(keys[0]));
        chk("run_ignore_ready", 32'(ld_ready), 0);

        // Clear at cnt=17, then start without reload must fail
        for (int i = 0; i < 16; i++) tick();
        chk("cnt17_key", 32'(key_out), 32'(keys[3]));
        chk("cnt17_win", 32'(win_idx), 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_idle("after_clear", 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("start_after_clear", 1'b1);

        // Partial load: start fails; then a write to slot 5 on the start edge
        do_reset();
        chk("rst2_err", 32'(ld_err), 0);
        for (int i = 0; i < 5; i++) load(i, keys[i]);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("partial_start", 1'b1);
        ld_valid = 1'b1; ld_idx = 3'd5; ld_data = keys[5]; start = 1'b1;
        tick();
        ld_valid = 1'b0; start = 1'b0;
        chk_idle("write_and_start", 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("late_start_sync_ready", 32'(ld_ready), 0);
        chk("late_start_sync_lock_rst", 32'(lock_rst), 1);
        chk("late_start_sync_key", 32'(key_out), 32'(keys[0]));

        // Out-of-range slot index sets the sticky error; a full load still runs
        do_reset();
        load(6, 18'h3FFFF);
        chk("bad_idx_err", 32'(ld_err), 1);
        chk("bad_idx_ready", 32'(ld_ready), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_idx_not_full", 32'(ld_ready), 1);
        load_all();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("bad_idx_sync_key", 32'(key_out), 32'(keys[0]));
        tick();
        chk("bad_idx_running", 32'(running), 1);
        chk("bad_idx_err_sticky", 32'(ld_err), 1);

        // Reset at cnt=12 returns everything to reset values
        for (int i = 0; i < 12; i++) tick();
        chk("cnt12_key", 32'(key_out), 32'(keys[2]));
        chk("cnt12_win", 32'(win_idx), 2);
        do_reset();
        chk_idle("rst_mid_run", 1'b0);

        // clear + start on the same edge: clear wins and slots are zeroized
        load_all();
        clear = 1'b1; start = 1'b1;
        tick();
        clear = 1'b0; start = 1'b0;
        chk_idle("clear_and_start", 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_idle("start_after_zeroize", 1'b1);

        // Slot 2 overwritten twice; the last write is what plays out
        do_reset();
        load_all();
        load(2, 18'h00001);
        load(2, 18'h3C2CB);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("ovr_cnt0_key", 32'(key_out), 32'(keys[0]));
        for (int i = 0; i < 10; i++) tick();
        chk("ovr_cnt10_key", 32'(key_out), 32'h3C2CB);
        for (int i = 0; i < 4; i++) tick();
        chk("ovr_cnt14_key", 32'(key_out), 32'h3C2CB);
        tick();
        chk("ovr_cnt15_key", 32'(key_out), 32'(keys[3]));
        chk("ovr_cnt15_win", 32'(win_idx), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
